// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit single-cycle CPU datapath.
// The register file and its storage cells size themselves from these values.
package cpu16_pkg;

    localparam int          DATA_W        = 16;
    localparam int          ADDR_W        = 3;
    localparam int          NUM_REGS      = 8;
    localparam logic [15:0] REG_RESET_VAL = 16'h0000;

endpackage : cpu16_pkg

// File: rtl/reg16_en.sv
// One register-file entry: a DATA_W-bit register with asynchronous
// active-high clear and a clock enable.
module reg16_en #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Storage: clear wins over any concurrent enable, otherwise load on enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule : reg16_en

// File: rtl/reg_file_8x16_chk.sv
// Simulation checker for the register file: control and address inputs
// must be known at every clock edge once reset is released.
module reg_file_8x16_chk #(
    parameter int ADDR_W = 3
) (
    input logic              i_clk,
    input logic              i_rst,
    input logic              i_we,
    input logic [ADDR_W-1:0] i_wa,
    input logic [ADDR_W-1:0] i_ra,
    input logic [ADDR_W-1:0] i_rb
);

    a_inputs_known: assert property (
        @(posedge i_clk) disable iff (i_rst) !$isunknown({i_we, i_wa, i_ra, i_rb})
    ) else $error("reg_file_8x16: X on WE/WA/RA/RB after reset release");

endmodule : reg_file_8x16_chk

// File: rtl/reg_file_8x16.sv
// Eight-entry x 16-bit register file: one synchronous write port and two
// combinational read ports with optional write bypass and hard-wired zero R0.
module reg_file_8x16 #(
    parameter int DATA_W    = cpu16_pkg::DATA_W,
    parameter int ADDR_W    = cpu16_pkg::ADDR_W,
    parameter int R0_ZERO   = 0,
    parameter int WR_BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB
);

    import cpu16_pkg::*;

    localparam bit ZERO_R0 = (R0_ZERO != 0);
    localparam bit BYPASS  = (WR_BYPASS != 0);

    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_en;
    logic [DATA_W-1:0]   w_mux_a;
    logic [DATA_W-1:0]   w_mux_b;
    logic                w_byp_a;
    logic                w_byp_b;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_en[gi] = WE && (WA == ADDR_W'(gi)) && !(ZERO_R0 && (gi == 0));

            reg16_en #(
                .DATA_W    (DATA_W),
                .RESET_VAL (DATA_W'(REG_RESET_VAL))
            ) u_reg (
                .i_clk (CLK),
                .i_rst (RST),
                .i_en  (w_en[gi]),
                .i_d   (WD),
                .o_q   (w_q[gi])
            );
        end
    endgenerate

    // Read-select muxes: the address bits {S2,S1,S0} pick one of the eight entries.
    always_comb begin
        w_mux_a = w_q[RA];
        w_mux_b = w_q[RB];
    end

    // Bypass is suppressed while RST is high so a cleared file never leaks WD.
    assign w_byp_a = BYPASS && WE && !RST && (RA == WA);
    assign w_byp_b = BYPASS && WE && !RST && (RB == WA);

    // Post-mux override: zero-forcing of R0 takes priority over bypass.
    always_comb begin
        QA = w_mux_a;
        if (ZERO_R0 && (RA == {ADDR_W{1'b0}})) begin
            QA = {DATA_W{1'b0}};
        end else if (w_byp_a) begin
            QA = WD;
        end else begin
            QA = w_mux_a;
        end
    end

    // Same override structure for port B.
    always_comb begin
        QB = w_mux_b;
        if (ZERO_R0 && (RB == {ADDR_W{1'b0}})) begin
            QB = {DATA_W{1'b0}};
        end else if (w_byp_b) begin
            QB = WD;
        end else begin
            QB = w_mux_b;
        end
    end

    reg_file_8x16_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .i_clk (CLK),
        .i_rst (RST),
        .i_we  (WE),
        .i_wa  (WA),
        .i_ra  (RA),
        .i_rb  (RB)
    );

endmodule : reg_file_8x16

// File: tb/tb_reg_file_8x16.sv
// Scoreboard bench: two register files share one stimulus stream, one with
// default parameters (bypass on, R0 ordinary) and one with R0_ZERO=1, WR_BYPASS=0.
module tb_reg_file_8x16;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] qa;
    logic [15:0] qb;
    logic [15:0] qa_z;
    logic [15:0] qb_z;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] za;
        logic [15:0] zb;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    reg_file_8x16 #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(0), .WR_BYPASS(1)) dut (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
        .RA(ra), .RB(rb), .QA(qa), .QB(qb)
    );

    reg_file_8x16 #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .WR_BYPASS(0)) dut_z (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
        .RA(ra), .RB(rb), .QA(qa_z), .QB(qb_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each sample request pops one expectation and compares all four outputs.
    always begin
        @(sample_ev);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry (t=%0t)", $time);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.name, ".QA"},   qa,   e.a);
            cmp({e.name, ".QB"},   qb,   e.b);
            cmp({e.name, ".QA_z"}, qa_z, e.za);
            cmp({e.name, ".QB_z"}, qb_z, e.zb);
        end
    end

    task automatic expect_rd(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] za, input logic [15:0] zb);
        exp_t e;
        e.name = name; e.a = a; e.b = b; e.za = za; e.zb = zb;
        exp_q.push_back(e);
        -> sample_ev;
        #0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        we = 1'b1; wa = addr; wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        logic [15:0] oh_a;
        logic [15:0] oh_b;
        rst = 1'b0; we = 1'b0; wa = 3'd0; wd = 16'h0000; ra = 3'd0; rb = 3'd0;
        #1 rst = 1'b1;

        // Reset state on every address
        for (int i = 0; i < 8; i++) begin
            #1 ra = 3'(i); rb = 3'(7 - i);
            #1 expect_rd("reset_state", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;

        // One-hot write walk then opposing sweeps of RA and RB
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 16'h0001 << i);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = 3'(i); rb = 3'(7 - i);
            oh_a = 16'h0001 << i;
            oh_b = 16'h0001 << (7 - i);
            #1 expect_rd("walk", oh_a, oh_b,
                         (i == 0) ? 16'h0000 : oh_a, (i == 7) ? 16'h0000 : oh_b);
        end

        // WE=0 hold over four edges
        @(negedge clk);
        we = 1'b0; wa = 3'd3; wd = 16'hFFFF; ra = 3'd3; rb = 3'd3;
        #1 expect_rd("hold_pre", 16'h0008, 16'h0008, 16'h0008, 16'h0008);
        repeat (4) @(posedge clk);
        @(negedge clk);
        expect_rd("hold_post", 16'h0008, 16'h0008, 16'h0008, 16'h0008);

        // Same-address write: bypass vs. no bypass, before and after the edge
        @(negedge clk);
        we = 1'b1; wa = 3'd5; wd = 16'hA5A5; ra = 3'd5; rb = 3'd0;
        #1 expect_rd("bypass_pre", 16'hA5A5, 16'h0001, 16'h0020, 16'h0000);
        @(posedge clk);
        #1 we = 1'b0;
        #1 expect_rd("bypass_post", 16'hA5A5, 16'h0001, 16'hA5A5, 16'h0000);

        // Write to R0: ordinary on one instance, discarded on the other
        @(negedge clk);
        we = 1'b1; wa = 3'd0; wd = 16'h1234; ra = 3'd0; rb = 3'd0;
        #1 expect_rd("r0_pre", 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 we = 1'b0;
        #1 expect_rd("r0_post", 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        ra = 3'd1;
        #1 expect_rd("r0_neighbour", 16'h0002, 16'h1234, 16'h0002, 16'h0000);

        // Reset asserted between edges while a write is pending across the next edge
        @(negedge clk);
        we = 1'b1; wa = 3'd2; wd = 16'hBEEF; ra = 3'd2; rb = 3'd5;
        #1 rst = 1'b1;
        #1 expect_rd("rst_immediate", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        ra = 3'd7; rb = 3'd0;
        #1 expect_rd("rst_immediate2", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; ra = 3'd2; rb = 3'd2;
        #1 expect_rd("rst_over_write", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // First edge after reset release performs the write
        do_write(3'd2, 16'h00C3);
        ra = 3'd2; rb = 3'd3;
        #1 expect_rd("post_reset_write", 16'h00C3, 16'h0000, 16'h00C3, 16'h0000);

        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file_8x16
